// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: game sequencer for the obstacle shift register.
// Owns run/pause/over state, paces scroll ticks, draws the spawn bit from a
// free-running LFSR and ramps speed/density with progress.
// Optional feature macro: OBSTACLE_SCHED_RAMP_EN (level, period and density ramp).
// Without it, level stays 0, period stays TICK_INIT and density stays 2.
//
// state   | meaning
// IDLE    | powered up, waiting for the first start
// RUN     | game active, scroll ticks generated
// PAUSED  | game frozen, tick counter holds
// OVER    | collision seen, waiting for start
module obstacle_scheduler #(
    parameter logic [15:0] TICK_INIT   = 16'd1000,
    parameter logic [15:0] TICK_STEP   = 16'd64,
    parameter logic [15:0] TICK_MIN    = 16'd200,
    parameter logic [15:0] LEVEL_TICKS = 16'd256,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        collision,
    output logic        scroll_en,
    output logic        rng_bit,
    output logic [1:0]  state,
    output logic [3:0]  level,
    output logic [15:0] score
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    // An all-zero Galois LFSR would lock up, so a zero seed is nudged to 1.
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'd0) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] score_q, score_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        scroll_en_q, scroll_en_d;
    logic        rng_bit_q, rng_bit_d;

    logic [15:0] period;
    logic [3:0]  density;
    logic        advance;
    logic        tick;
    logic        game_clear;
    logic        sample;

`ifdef OBSTACLE_SCHED_RAMP_EN
    // Subtracting TICK_STEP from anything below this would cross the floor.
    localparam logic [16:0] STEP_FLOOR = {1'b0, TICK_STEP} + {1'b0, TICK_MIN};

    logic [15:0] period_q, period_d;
    logic [15:0] level_cnt_q, level_cnt_d;
    logic [3:0]  level_q, level_d;

    assign period  = period_q;
    assign density = 4'd2 + {2'b00, level_q[3:2]};
    assign level   = level_q;

    // Difficulty ramp: every LEVEL_TICKS ticks raise level and shorten the period.
    always_comb begin
        period_d    = period_q;
        level_cnt_d = level_cnt_q;
        level_d     = level_q;
        if (game_clear) begin
            period_d    = TICK_INIT;
            level_cnt_d = 16'd0;
            level_d     = 4'd0;
        end else if (tick) begin
            if (level_cnt_q == LEVEL_TICKS - 16'd1) begin
                level_cnt_d = 16'd0;
                level_d     = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                period_d    = ({1'b0, period_q} < STEP_FLOOR) ? TICK_MIN : period_q - TICK_STEP;
            end else begin
                level_cnt_d = level_cnt_q + 16'd1;
            end
        end
    end

    // Ramp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q    <= TICK_INIT;
            level_cnt_q <= 16'd0;
            level_q     <= 4'd0;
        end else begin
            period_q    <= period_d;
            level_cnt_q <= level_cnt_d;
            level_q     <= level_d;
        end
    end
`else
    // Ramp parameters have no effect when ramping is compiled out.
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{TICK_STEP, TICK_MIN, LEVEL_TICKS};

    assign period  = TICK_INIT;
    assign density = 4'd2;
    assign level   = 4'd0;
`endif

    // Next-state: FSM, interval counter, score, spawn sample and LFSR.
    always_comb begin
        advance    = (state_q == ST_RUN) && !pause && !collision;
        tick       = advance && (cnt_q == period - 16'd1);
        game_clear = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
        sample     = {1'b0, lfsr_q[2:0]} < density;
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (collision)  state_d = ST_OVER;
                else if (pause) state_d = ST_PAUSED;
            end
            ST_PAUSED: if (!pause) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        cnt_d       = cnt_q;
        score_d     = score_q;
        scroll_en_d = 1'b0;
        rng_bit_d   = rng_bit_q;
        if (game_clear) begin
            cnt_d   = 16'd0;
            score_d = 16'd0;
        end else if (tick) begin
            cnt_d       = 16'd0;
            scroll_en_d = 1'b1;
            score_d     = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
            rng_bit_d   = sample;
        end else if (advance) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State and datapath registers; the LFSR runs in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            score_q     <= 16'd0;
            lfsr_q      <= SEED_EFF;
            scroll_en_q <= 1'b0;
            rng_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            lfsr_q      <= lfsr_d;
            scroll_en_q <= scroll_en_d;
            rng_bit_q   <= rng_bit_d;
        end
    end

    assign scroll_en = scroll_en_q;
    assign rng_bit   = rng_bit_q;
    assign state     = state_q;
    assign score     = score_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Testbench for obstacle_scheduler with small tick parameters.
module tb_obstacle_scheduler;
    localparam int T_INIT  = 8;
    localparam int T_STEP  = 2;
    localparam int T_MIN   = 4;
    localparam int L_TICKS = 4;
`ifdef OBSTACLE_SCHED_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    typedef struct {
        int cyc;
        int score;
        int level;
        int density;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        collision = 1'b0;
    logic        scroll_en, rng_bit;
    logic [1:0]  state;
    logic [3:0]  level;
    logic [15:0] score;
    logic        z_scroll_en, z_rng_bit;
    logic [1:0]  z_state;
    logic [3:0]  z_level;
    logic [15:0] z_score;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t sb[$];
    logic [15:0] m_lfsr, m_lfsr_prev, m0_lfsr;

    obstacle_scheduler #(
        .TICK_INIT(16'd8), .TICK_STEP(16'd2), .TICK_MIN(16'd4),
        .LEVEL_TICKS(16'd4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .collision(collision),
        .scroll_en(scroll_en), .rng_bit(rng_bit), .state(state), .level(level), .score(score)
    );

    obstacle_scheduler #(
        .TICK_INIT(16'd8), .TICK_STEP(16'd2), .TICK_MIN(16'd4),
        .LEVEL_TICKS(16'd4), .LFSR_SEED(16'h0000)
    ) dut_s0 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .collision(collision),
        .scroll_en(z_scroll_en), .rng_bit(z_rng_bit), .state(z_state), .level(z_level), .score(z_score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSRs; m_lfsr_prev is the value the DUT sampled at the last edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr      <= 16'hACE1;
            m_lfsr_prev <= 16'hACE1;
            m0_lfsr     <= 16'h0001;
        end else begin
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= lfsr_next(m_lfsr);
            m0_lfsr     <= lfsr_next(m0_lfsr);
        end
    end

    function automatic int lvl_after(input int k);
        if (!RAMP) return 0;
        return (k / L_TICKS > 15) ? 15 : k / L_TICKS;
    endfunction

    function automatic int gap_for(input int k);
        int p;
        p = T_INIT;
        for (int j = 1; j < k; j++)
            if (RAMP && (j % L_TICKS == 0)) p = (p < T_STEP + T_MIN) ? T_MIN : p - T_STEP;
        return p;
    endfunction

    task automatic push_ticks(input int base, input int k_from, input int k_to);
        int t;
        exp_t e;
        t = base;
        for (int k = k_from; k <= k_to; k++) begin
            t += gap_for(k);
            e.cyc = t;
            e.score = k;
            e.level = lvl_after(k);
            e.density = 2 + (lvl_after(k - 1) >> 2);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; collision = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic do_start(output int e0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; start = 1'b0; pause = 1'b0; collision = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (scroll_en !== 1'b0) begin failures++; $display("FAIL reset_scroll_en: got %b want 0", scroll_en); end
        checks++; if (rng_bit !== 1'b0) begin failures++; $display("FAIL reset_rng_bit: got %b want 0", rng_bit); end
        checks++; if (score !== 16'd0) begin failures++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (dut_s0.lfsr_q !== 16'h0001) begin failures++; $display("FAIL reset_zero_seed: got %h want 0001", dut_s0.lfsr_q); end
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (state !== 2'd0 || scroll_en !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL idle_hold: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_ramp();
        int e0, waited;
        logic exp_rng;
        exp_t e;
        do_reset();
        do_start(e0);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL ramp_start_state: got %0d want 1", state); end
        push_ticks(e0, 1, 100);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            waited = 0;
            do begin @(negedge clk); waited++; end while (scroll_en !== 1'b1 && waited < 40);
            checks++;
            if (scroll_en !== 1'b1) begin
                failures++; $display("FAIL ramp_timeout: tick %0d got no pulse want pulse at cycle %0d", e.score, e.cyc);
                return;
            end
            exp_rng = ({1'b0, m_lfsr_prev[2:0]} < e.density);
            checks++; if (cyc != e.cyc) begin failures++; $display("FAIL ramp_cycle: tick %0d got cycle %0d want %0d", e.score, cyc, e.cyc); end
            checks++; if (score !== e.score[15:0]) begin failures++; $display("FAIL ramp_score: got %0d want %0d", score, e.score); end
            checks++; if (level !== e.level[3:0]) begin failures++; $display("FAIL ramp_level: tick %0d got %0d want %0d", e.score, level, e.level); end
            checks++; if (rng_bit !== exp_rng) begin failures++; $display("FAIL ramp_rng: tick %0d got %b want %b", e.score, rng_bit, exp_rng); end
            @(negedge clk);
            checks++; if (scroll_en !== 1'b0) begin failures++; $display("FAIL ramp_width: tick %0d got %b want 0", e.score, scroll_en); end
            checks++; if (rng_bit !== exp_rng) begin failures++; $display("FAIL ramp_rng_hold: got %b want %b", rng_bit, exp_rng); end
        end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL ramp_end_state: got %0d want 1", state); end
    endtask

    task automatic test_pause();
        int e0, waited;
        exp_t e;
        do_reset();
        do_start(e0);
        push_ticks(e0, 1, 1);
        e = sb.pop_front();
        waited = 0;
        do begin @(negedge clk); waited++; end while (scroll_en !== 1'b1 && waited < 40);
        checks++; if (cyc != e.cyc || score !== 16'd1) begin failures++; $display("FAIL pause_first_tick: got cycle %0d score %0d want cycle %0d score 1", cyc, score, e.cyc); end
        repeat (5) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 2'd2 || scroll_en !== 1'b0 || score !== 16'd1) begin
                failures++; $display("FAIL pause_hold: cycle %0d got state %0d scroll_en %b score %0d want 2 0 1", i, state, scroll_en, score);
            end
        end
        pause = 1'b0;
        push_ticks(e0 + 8 + 21, 2, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            waited = 0;
            do begin @(negedge clk); waited++; end while (scroll_en !== 1'b1 && waited < 40);
            checks++; if (scroll_en !== 1'b1 || cyc != e.cyc) begin failures++; $display("FAIL pause_resume_cycle: got cycle %0d pulse %b want cycle %0d", cyc, scroll_en, e.cyc); end
            checks++; if (score !== e.score[15:0]) begin failures++; $display("FAIL pause_resume_score: got %0d want %0d", score, e.score); end
        end
    endtask

    task automatic test_collision();
        int e0, e1, waited;
        exp_t e;
        do_reset();
        do_start(e0);
        push_ticks(e0, 1, 1);
        e = sb.pop_front();
        waited = 0;
        do begin @(negedge clk); waited++; end while (scroll_en !== 1'b1 && waited < 40);
        checks++; if (cyc != e.cyc || score !== 16'd1) begin failures++; $display("FAIL coll_first_tick: got cycle %0d score %0d want cycle %0d score 1", cyc, score, e.cyc); end
        repeat (7) @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        checks++; if (scroll_en !== 1'b0) begin failures++; $display("FAIL coll_no_pulse: got %b want 0", scroll_en); end
        checks++; if (score !== 16'd1) begin failures++; $display("FAIL coll_score: got %0d want 1", score); end
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL coll_state: got %0d want 3", state); end
        for (int i = 0; i < 12; i++) begin
            collision = (i >= 3 && i < 6);
            @(negedge clk);
            checks++;
            if (state !== 2'd3 || scroll_en !== 1'b0 || score !== 16'd1) begin
                failures++; $display("FAIL over_hold: cycle %0d got state %0d scroll_en %b score %0d want 3 0 1", i, state, scroll_en, score);
            end
        end
        collision = 1'b0;
        do_start(e1);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL restart_state: got %0d want 1", state); end
        checks++; if (score !== 16'd0) begin failures++; $display("FAIL restart_score: got %0d want 0", score); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL restart_level: got %0d want 0", level); end
        push_ticks(e1, 1, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            waited = 0;
            do begin @(negedge clk); waited++; end while (scroll_en !== 1'b1 && waited < 40);
            checks++; if (scroll_en !== 1'b1 || cyc != e.cyc) begin failures++; $display("FAIL restart_cycle: got cycle %0d pulse %b want cycle %0d", cyc, scroll_en, e.cyc); end
            checks++; if (score !== e.score[15:0] || level !== e.level[3:0]) begin failures++; $display("FAIL restart_score_level: got %0d/%0d want %0d/%0d", score, level, e.score, e.level); end
        end
    endtask

    task automatic test_priority();
        int e0, waited;
        exp_t e;
        do_reset();
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        e0 = cyc - 3;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL prio_start_state: got %0d want 1", state); end
        push_ticks(e0, 1, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            waited = 0;
            do begin @(negedge clk); waited++; end while (scroll_en !== 1'b1 && waited < 40);
            checks++; if (scroll_en !== 1'b1 || cyc != e.cyc) begin failures++; $display("FAIL prio_start_ignored: got cycle %0d pulse %b want cycle %0d", cyc, scroll_en, e.cyc); end
        end
        @(negedge clk);
        pause = 1'b1;
        collision = 1'b1;
        @(negedge clk);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL prio_coll_over_pause: got %0d want 3", state); end
        pause = 1'b0;
        collision = 1'b0;
        @(negedge clk);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL prio_over_stays: got %0d want 3", state); end
    endtask

    task automatic test_reset_mid();
        int e0, waited;
        exp_t e;
        do_reset();
        do_start(e0);
        push_ticks(e0, 1, 1);
        e = sb.pop_front();
        waited = 0;
        do begin @(negedge clk); waited++; end while (scroll_en !== 1'b1 && waited < 40);
        checks++; if (scroll_en !== 1'b1 || cyc != e.cyc) begin failures++; $display("FAIL midrst_pulse: got cycle %0d pulse %b want cycle %0d", cyc, scroll_en, e.cyc); end
        #1 rst = 1'b1;
        #1;
        checks++; if (scroll_en !== 1'b0) begin failures++; $display("FAIL midrst_scroll_en: got %b want 0", scroll_en); end
        checks++; if (state !== 2'd0 || score !== 16'd0 || level !== 4'd0 || rng_bit !== 1'b0) begin
            failures++; $display("FAIL midrst_regs: got state %0d score %0d level %0d rng %b want 0 0 0 0", state, score, level, rng_bit);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_lfsr();
        int zeros, mism;
        do_reset();
        zeros = 0;
        mism = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (dut_s0.lfsr_q == 16'h0000) zeros++;
            if (dut_s0.lfsr_q !== m0_lfsr) mism++;
        end
        checks++; if (zeros != 0) begin failures++; $display("FAIL lfsr_zero: got %0d zero states want 0", zeros); end
        checks++; if (mism != 0) begin failures++; $display("FAIL lfsr_sequence: got %0d differing cycles want 0", mism); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_pause();
        test_collision();
        test_priority();
        test_reset_mid();
        test_lfsr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
